// File: rtl/alu_div_sequencer.sv
// Purpose: unsigned restoring divider sequencing trial subtractions through a shared external add/sub ALU.
// Latency: done pulses DATA_BITS+1 cycles after an accepted start; a zero divisor finishes 1 cycle after start.
// Backpressure: start is sampled only in IDLE; starts seen while busy are dropped, never queued.
module alu_div_sequencer #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] dividend,
    input  logic [DATA_BITS-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero,
    output logic [DATA_BITS-1:0] quotient,
    output logic [DATA_BITS-1:0] remainder,
    output logic [DATA_BITS-1:0] alu_a,
    output logic [DATA_BITS-1:0] alu_b,
    output logic                 alu_cin,
    input  logic [DATA_BITS-1:0] alu_result,
    input  logic                 alu_cout
);

    localparam int CW = $clog2(DATA_BITS) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [DATA_BITS-1:0]   r_rem;
    logic [DATA_BITS-1:0]   r_quo;
    logic [DATA_BITS-1:0]   r_dvs;
    logic [CW-1:0]          r_count;
    logic [DATA_BITS-1:0]   r_quotient;
    logic [DATA_BITS-1:0]   r_remainder;
    logic                   r_div_zero;

    // Partial remainder shifted left with the next dividend bit pulled in from Q.
    // R stays below the divisor, so this never needs an extra bit.
    logic [DATA_BITS-1:0]   w_shift_a;
    logic [DATA_BITS-1:0]   w_rem_next;
    logic [DATA_BITS-1:0]   w_quo_next;
    logic                   w_last;

    assign w_shift_a  = {r_rem[DATA_BITS-2:0], r_quo[DATA_BITS-1]};
    // ALU carry-out in subtract mode means no borrow: keep the difference and set the quotient bit.
    assign w_rem_next = alu_cout ? alu_result : w_shift_a;
    assign w_quo_next = {r_quo[DATA_BITS-2:0], alu_cout};
    assign w_last     = (r_count == CW'(DATA_BITS - 1));

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

    // State register; reset aborts any operation in flight without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus ALU drive and handshake outputs, all from registered state.
    always_comb begin
        w_next_state = r_state;
        alu_a        = '0;
        alu_b        = '0;
        alu_cin      = 1'b0;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (divisor != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                alu_a   = w_shift_a;
                alu_b   = r_dvs;
                alu_cin = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Working registers and published results; results only move on a completed op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            r_dvs   <= divisor;
                            r_quo   <= dividend;
                            r_rem   <= '0;
                            r_count <= '0;
                        end else begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_div_zero  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_quotient  <= w_quo_next;
                        r_remainder <= w_rem_next;
                        r_div_zero  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Purpose: directed checks of alu_div_sequencer with a behavioural add/sub ALU in the loop.
// Latency: per-cycle busy/done/alu_cin traces compared against hand-derived cycle masks.
// Backpressure: exercises starts during RUN/DONE and a start held high across two ops.
module tb_alu_div_sequencer;

    localparam int DB = 8;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [DB-1:0] dividend;
    logic [DB-1:0] divisor;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [DB-1:0] quotient;
    logic [DB-1:0] remainder;
    logic [DB-1:0] alu_a;
    logic [DB-1:0] alu_b;
    logic          alu_cin;
    logic [DB-1:0] alu_result;
    logic          alu_cout;

    int n_chk;
    int n_err;

    logic [31:0] bv;
    logic [31:0] dv;
    logic [31:0] cv;

    alu_div_sequencer #(.DATA_BITS(DB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .quotient   (quotient),
        .remainder  (remainder),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    // Shared ALU: cin=1 selects a - b (a + ~b + 1), cin=0 selects a + b.
    logic [DB:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, alu_a} + {1'b0, (alu_cin ? ~alu_b : alu_b)} + {{DB{1'b0}}, alu_cin};
    end
    assign alu_result = alu_sum[DB-1:0];
    assign alu_cout   = alu_sum[DB];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start an op whose start is accepted at edge 0; trace cycles 1..ncyc.
    // smask[c] is the start level driven during cycle c; a2/b2 replace the operands after edge 0.
    task automatic run(input logic [DB-1:0] a, input logic [DB-1:0] b,
                       input logic [DB-1:0] a2, input logic [DB-1:0] b2,
                       input logic [31:0] smask, input int ncyc,
                       output logic [31:0] busy_v, output logic [31:0] done_v,
                       output logic [31:0] cin_v);
        busy_v   = '0;
        done_v   = '0;
        cin_v    = '0;
        dividend = a;
        divisor  = b;
        start    = smask[0];
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            busy_v[c] = busy;
            done_v[c] = done;
            cin_v[c]  = alu_cin;
            dividend  = a2;
            divisor   = b2;
            start     = smask[c];
        end
        start = 1'b0;
    endtask

    task automatic simple(input string tag, input logic [DB-1:0] a, input logic [DB-1:0] b,
                          input logic [DB-1:0] eq, input logic [DB-1:0] er, input logic ez);
        run(a, b, 8'hAA, 8'h55, 32'h1, 11, bv, dv, cv);
        chk({tag, " q"}, 32'(quotient), 32'(eq));
        chk({tag, " r"}, 32'(remainder), 32'(er));
        chk({tag, " dz"}, 32'(div_zero), 32'(ez));
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst dz", 32'(div_zero), 32'd0);
        chk("rst q", 32'(quotient), 32'd0);
        chk("rst r", 32'(remainder), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 100/7 with full cycle traces: busy 1..9, done 9 only, cin 1..8.
        run(8'd100, 8'd7, 8'd0, 8'd0, 32'h1, 11, bv, dv, cv);
        chk("100/7 busy", bv, 32'h0000_03FE);
        chk("100/7 done", dv, 32'h0000_0200);
        chk("100/7 cin", cv, 32'h0000_01FE);
        chk("100/7 q", 32'(quotient), 32'd14);
        chk("100/7 r", 32'(remainder), 32'd2);
        chk("100/7 dz", 32'(div_zero), 32'd0);

        simple("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        simple("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        simple("255/200", 8'd255, 8'd200, 8'd1, 8'd55, 1'b0);

        // Divide by zero finishes in cycle 1 without touching the ALU.
        run(8'd200, 8'd0, 8'd0, 8'd0, 32'h1, 3, bv, dv, cv);
        chk("div0 busy", bv, 32'h0000_0002);
        chk("div0 done", dv, 32'h0000_0002);
        chk("div0 cin", cv, 32'h0);
        chk("div0 q", 32'(quotient), 32'd255);
        chk("div0 r", 32'(remainder), 32'd200);
        chk("div0 dz", 32'(div_zero), 32'd1);
        simple("10/3", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0);

        // Starts during RUN (cycle 3) and DONE (cycle 9) with other operands are dropped.
        run(8'd100, 8'd7, 8'd50, 8'd3, (32'h1 | (32'h1 << 3) | (32'h1 << 9)), 12, bv, dv, cv);
        chk("ign done", dv, 32'h0000_0200);
        chk("ign busy", bv, 32'h0000_03FE);
        chk("ign q", 32'(quotient), 32'd14);
        chk("ign r", 32'(remainder), 32'd2);

        // Start held through cycle 18: second op accepted at edge 10, done at 19.
        run(8'd60, 8'd6, 8'd60, 8'd6, 32'h0007_FFFF, 21, bv, dv, cv);
        chk("hold done", dv, (32'h1 << 9) | (32'h1 << 19));
        chk("hold busy", bv, 32'h000F_FBFE);
        chk("hold q", 32'(quotient), 32'd10);
        chk("hold r", 32'(remainder), 32'd0);

        // Asynchronous reset in the middle of cycle 4 of a run.
        simple("pre 200/9", 8'd200, 8'd9, 8'd22, 8'd2, 1'b0);
        run(8'd100, 8'd7, 8'd0, 8'd0, 32'h1, 4, bv, dv, cv);
        chk("arst busy before", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst done", 32'(done), 32'd0);
        chk("arst q", 32'(quotient), 32'd0);
        chk("arst r", 32'(remainder), 32'd0);
        chk("arst cin", 32'(alu_cin), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run(8'd100, 8'd7, 8'd0, 8'd0, 32'h1, 11, bv, dv, cv);
        chk("post done", dv, 32'h0000_0200);
        chk("post q", 32'(quotient), 32'd14);
        chk("post r", 32'(remainder), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
